// File: rtl/passive_alarm_pkg.sv
// passive_alarm_pkg
//   Shared definitions for the passive alarm sequencer:
//   - alarm_state_t : FSM state type and its fixed encodings
//   - DEF_*         : default delay / beep constants
//   - ALARM_CNT_W   : width of the optional alarm event counter
//   - max3          : helper used to size the shared delay counter
package passive_alarm_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED    = 3'd0,
    ST_ARM_DELAY   = 3'd1,
    ST_ARMED       = 3'd2,
    ST_ENTRY_DELAY = 3'd3,
    ST_ALARM       = 3'd4
  } alarm_state_t;

  localparam int DEF_ARM_DELAY_CYC   = 16;
  localparam int DEF_ENTRY_DELAY_CYC = 8;
  localparam int DEF_ALARM_CYC       = 32;
  localparam int DEF_BEEP_HALF       = 2;

  localparam int ALARM_CNT_W = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/passive_alarm_ctrl_beep_gen.sv
// beep_gen
//   Square-wave tone generator. bcnt counts modulo BEEP_HALF and tone
//   toggles each time bcnt wraps, giving a period of 2*BEEP_HALF cycles.
//   A synchronous clear restarts the waveform low with bcnt at zero.
// Ports:
//   clk        in  system clock
//   reset      in  asynchronous active-high reset
//   i_clr      in  restart the waveform at this edge
//   o_tone_nxt out value tone takes at the coming edge, so a downstream
//                  register can follow tone without an extra cycle of lag
module beep_gen #(
  parameter int BEEP_HALF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_tone_nxt
);

  localparam int BW = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;

  logic [BW-1:0] r_bcnt;
  logic [BW-1:0] w_bcnt_nxt;
  logic          r_tone;
  logic          w_tone_nxt;

  always_comb begin
    w_bcnt_nxt = r_bcnt;
    w_tone_nxt = r_tone;
    if (i_clr) begin
      w_bcnt_nxt = '0;
      w_tone_nxt = 1'b0;
    end else if (r_bcnt == BW'(BEEP_HALF - 1)) begin
      w_bcnt_nxt = '0;
      w_tone_nxt = ~r_tone;
    end else begin
      w_bcnt_nxt = r_bcnt + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bcnt <= '0;
      r_tone <= 1'b0;
    end else begin
      r_bcnt <= w_bcnt_nxt;
      r_tone <= w_tone_nxt;
    end
  end

  assign o_tone_nxt = w_tone_nxt;

endmodule

// File: rtl/passive_alarm_ctrl.sv
// passive_alarm_ctrl
//   Alarm sequencer downstream of the passive security block. Runs a timed
//   DISARMED -> ARM_DELAY -> ARMED -> ENTRY_DELAY -> ALARM state machine and
//   drives siren, buzzer and armed indicator, all registered from the next
//   state so they change on the same edge as the state.
// Ports:
//   clk              in   system clock (rising edge)
//   reset            in   asynchronous active-high reset
//   PassiveSignal_s  in   arm request level
//   PassiveSignal_b  in   warning-tone request level
//   OpenDoorSign     in   door open
//   IgnitionSignalOn in   valid key / ignition, disarms from any state
//   Siren            out  high only in ALARM
//   Buzzer           out  tone in ENTRY_DELAY, tone & PassiveSignal_b in
//                         DISARMED, otherwise low
//   ArmedLed         out  high in ARMED, ENTRY_DELAY and ALARM
//   AlarmState       out  current state encoding
//   AlarmCount       out  (PASSIVE_ALARM_LOG_EN only) saturating count of
//                         ENTRY_DELAY -> ALARM transitions, cleared by reset
// Build option:
//   PASSIVE_ALARM_LOG_EN adds the AlarmCount port and counter.
module passive_alarm_ctrl
  import passive_alarm_pkg::*;
#(
  parameter int ARM_DELAY_CYC   = DEF_ARM_DELAY_CYC,
  parameter int ENTRY_DELAY_CYC = DEF_ENTRY_DELAY_CYC,
  parameter int ALARM_CYC       = DEF_ALARM_CYC,
  parameter int BEEP_HALF       = DEF_BEEP_HALF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PassiveSignal_s,
  input  logic       PassiveSignal_b,
  input  logic       OpenDoorSign,
  input  logic       IgnitionSignalOn,
  output logic       Siren,
  output logic       Buzzer,
  output logic       ArmedLed,
  output logic [2:0] AlarmState
`ifdef PASSIVE_ALARM_LOG_EN
  ,
  output logic [ALARM_CNT_W-1:0] AlarmCount
`endif
);

  localparam int MAX_DLY = max3(ARM_DELAY_CYC, ENTRY_DELAY_CYC, ALARM_CYC);
  localparam int DLY_W   = $clog2(MAX_DLY) + 1;

  localparam logic [DLY_W-1:0] LD_ARM   = DLY_W'(ARM_DELAY_CYC - 1);
  localparam logic [DLY_W-1:0] LD_ENTRY = DLY_W'(ENTRY_DELAY_CYC - 1);
  localparam logic [DLY_W-1:0] LD_ALARM = DLY_W'(ALARM_CYC - 1);

  alarm_state_t     r_state;
  alarm_state_t     w_state_nxt;
  logic [DLY_W-1:0] r_dly;
  logic [DLY_W-1:0] w_dly_nxt;
  logic             r_door_q;
  logic             w_door_rise;
  logic             w_state_chg;
  logic             w_tone_nxt;
  logic             r_siren;
  logic             r_buzzer;
  logic             r_armed;

  assign w_door_rise = OpenDoorSign & ~r_door_q;
  assign w_state_chg = (w_state_nxt != r_state);

  // Tone restarts from a known phase whenever the state changes, so the
  // entry-delay beep always begins low on the entry edge.
  beep_gen #(
    .BEEP_HALF (BEEP_HALF)
  ) u_beep (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_state_chg),
    .o_tone_nxt (w_tone_nxt)
  );

  // Next-state and delay-counter logic. Each timed state loads N-1 on entry
  // and leaves when the counter reads zero, giving an N-cycle dwell.
  always_comb begin
    w_state_nxt = r_state;
    w_dly_nxt   = r_dly;
    case (r_state)
      ST_DISARMED: begin
        if (PassiveSignal_s && !IgnitionSignalOn && !OpenDoorSign) begin
          w_state_nxt = ST_ARM_DELAY;
          w_dly_nxt   = LD_ARM;
        end
      end
      ST_ARM_DELAY: begin
        if (IgnitionSignalOn || !PassiveSignal_s) begin
          w_state_nxt = ST_DISARMED;
          w_dly_nxt   = '0;
        end else if (OpenDoorSign) begin
          // An open door holds off arming; the full delay restarts.
          w_dly_nxt = LD_ARM;
        end else if (r_dly == '0) begin
          w_state_nxt = ST_ARMED;
        end else begin
          w_dly_nxt = r_dly - DLY_W'(1);
        end
      end
      ST_ARMED: begin
        if (IgnitionSignalOn) begin
          w_state_nxt = ST_DISARMED;
          w_dly_nxt   = '0;
        end else if (w_door_rise) begin
          w_state_nxt = ST_ENTRY_DELAY;
          w_dly_nxt   = LD_ENTRY;
        end
      end
      ST_ENTRY_DELAY: begin
        if (IgnitionSignalOn) begin
          w_state_nxt = ST_DISARMED;
          w_dly_nxt   = '0;
        end else if (r_dly == '0) begin
          w_state_nxt = ST_ALARM;
          w_dly_nxt   = LD_ALARM;
        end else begin
          w_dly_nxt = r_dly - DLY_W'(1);
        end
      end
      ST_ALARM: begin
        if (IgnitionSignalOn) begin
          w_state_nxt = ST_DISARMED;
          w_dly_nxt   = '0;
        end else if (r_dly == '0) begin
          // Back to ARMED; only a fresh door rising edge re-triggers.
          w_state_nxt = ST_ARMED;
        end else begin
          w_dly_nxt = r_dly - DLY_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_DISARMED;
        w_dly_nxt   = '0;
      end
    endcase
  end

  // State, counter, door history and outputs, all decoded from next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_DISARMED;
      r_dly    <= '0;
      r_door_q <= 1'b0;
      r_siren  <= 1'b0;
      r_buzzer <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dly    <= w_dly_nxt;
      r_door_q <= OpenDoorSign;
      r_siren  <= (w_state_nxt == ST_ALARM);
      r_armed  <= (w_state_nxt == ST_ARMED) ||
                  (w_state_nxt == ST_ENTRY_DELAY) ||
                  (w_state_nxt == ST_ALARM);
      case (w_state_nxt)
        ST_ENTRY_DELAY: r_buzzer <= w_tone_nxt;
        ST_DISARMED:    r_buzzer <= w_tone_nxt & PassiveSignal_b;
        default:        r_buzzer <= 1'b0;
      endcase
    end
  end

`ifdef PASSIVE_ALARM_LOG_EN
  logic [ALARM_CNT_W-1:0] r_alarm_cnt;

  // Saturating log of alarms that actually sounded; disarm leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alarm_cnt <= '0;
    end else if ((r_state == ST_ENTRY_DELAY) && (w_state_nxt == ST_ALARM) &&
                 (r_alarm_cnt != '1)) begin
      r_alarm_cnt <= r_alarm_cnt + ALARM_CNT_W'(1);
    end
  end

  assign AlarmCount = r_alarm_cnt;
`endif

  assign Siren      = r_siren;
  assign Buzzer     = r_buzzer;
  assign ArmedLed   = r_armed;
  assign AlarmState = r_state;

endmodule

// File: tb/tb_passive_alarm_ctrl.sv
// tb_passive_alarm_ctrl
//   Directed-vector bench for passive_alarm_ctrl with default parameters
//   (arm 16, entry 8, alarm 32, beep half-period 2). Inputs are driven and
//   outputs sampled 1 ns after each rising edge.
module tb_passive_alarm_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       PassiveSignal_s;
  logic       PassiveSignal_b;
  logic       OpenDoorSign;
  logic       IgnitionSignalOn;
  logic       Siren;
  logic       Buzzer;
  logic       ArmedLed;
  logic [2:0] AlarmState;
`ifdef PASSIVE_ALARM_LOG_EN
  logic [3:0] AlarmCount;
`endif

  int n_chk = 0;
  int n_err = 0;

  passive_alarm_ctrl #(
    .ARM_DELAY_CYC   (16),
    .ENTRY_DELAY_CYC (8),
    .ALARM_CYC       (32),
    .BEEP_HALF       (2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .PassiveSignal_s  (PassiveSignal_s),
    .PassiveSignal_b  (PassiveSignal_b),
    .OpenDoorSign     (OpenDoorSign),
    .IgnitionSignalOn (IgnitionSignalOn),
    .Siren            (Siren),
    .Buzzer           (Buzzer),
    .ArmedLed         (ArmedLed),
    .AlarmState       (AlarmState)
`ifdef PASSIVE_ALARM_LOG_EN
    ,
    .AlarmCount       (AlarmCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Beep waveform from the clear edge: edges +1..+8 after restart.
  logic bz_exp [0:7];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bz_exp[0] = 1'b0; bz_exp[1] = 1'b1; bz_exp[2] = 1'b1; bz_exp[3] = 1'b0;
    bz_exp[4] = 1'b0; bz_exp[5] = 1'b1; bz_exp[6] = 1'b1; bz_exp[7] = 1'b0;

    reset = 1'b1;
    PassiveSignal_s  = 1'b0;
    PassiveSignal_b  = 1'b0;
    OpenDoorSign     = 1'b0;
    IgnitionSignalOn = 1'b0;

    // Reset state before any edge
    #3;
    chk("rst_state",  AlarmState, 0);
    chk("rst_siren",  Siren, 0);
    chk("rst_buzzer", Buzzer, 0);
    chk("rst_led",    ArmedLed, 0);
    tick();
    chk("rst_hold_state", AlarmState, 0);

    // Warning tone in DISARMED
    reset = 1'b0;
    PassiveSignal_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("warn_bz%0d", i), Buzzer, bz_exp[i]);
    end
    chk("warn_state", AlarmState, 0);
    PassiveSignal_b = 1'b0;
    tick();
    chk("warn_off0", Buzzer, 0);
    tick();
    chk("warn_off1", Buzzer, 0);
    tick();
    chk("warn_off2", Buzzer, 0);

    // Arm: ARM_DELAY on the next edge, ARMED 16 edges later
    PassiveSignal_s = 1'b1;
    tick();
    chk("arm_enter", AlarmState, 1);
    chk("arm_led0", ArmedLed, 0);
    tickn(15);
    chk("arm_last", AlarmState, 1);
    tick();
    chk("armed_state", AlarmState, 2);
    chk("armed_led", ArmedLed, 1);
    chk("armed_siren", Siren, 0);

    // Intrusion: entry delay with beep, then siren for 32 cycles
    OpenDoorSign = 1'b1;
    tick();
    chk("entry_state", AlarmState, 3);
    chk("entry_bz0", Buzzer, 0);
    chk("entry_led", ArmedLed, 1);
    OpenDoorSign = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("entry_bz%0d", i + 1), Buzzer, bz_exp[i]);
    end
    chk("entry_last", AlarmState, 3);
    chk("entry_siren", Siren, 0);
    tick();
    chk("alarm_state", AlarmState, 4);
    chk("alarm_siren", Siren, 1);
    chk("alarm_bz", Buzzer, 0);
    tickn(4);
    OpenDoorSign = 1'b1;          // door rise in ALARM is ignored
    tick();
    OpenDoorSign = 1'b0;
    chk("alarm_door_ign", AlarmState, 4);
    tickn(26);
    chk("alarm_last", AlarmState, 4);
    chk("alarm_last_siren", Siren, 1);
    tick();
    chk("alarm_done_state", AlarmState, 2);
    chk("alarm_done_siren", Siren, 0);
    chk("alarm_done_led", ArmedLed, 1);
    tick();
    chk("no_retrigger", AlarmState, 2);

    // Disarm on cycle 5 of ENTRY_DELAY
    OpenDoorSign = 1'b1;
    tick();
    chk("dis_entry", AlarmState, 3);
    OpenDoorSign = 1'b0;
    tickn(4);
    IgnitionSignalOn = 1'b1;
    tick();
    chk("dis_state", AlarmState, 0);
    chk("dis_siren", Siren, 0);
    chk("dis_led", ArmedLed, 0);
    IgnitionSignalOn = 1'b0;

    // Door during arming reloads the counter
    tick();
    chk("door_arm_enter", AlarmState, 1);
    tickn(9);
    OpenDoorSign = 1'b1;
    tick();
    chk("door_arm_hold", AlarmState, 1);
    OpenDoorSign = 1'b0;
    tickn(15);
    chk("door_arm_last", AlarmState, 1);
    tick();
    chk("door_arm_armed", AlarmState, 2);

    // Ignition beats a simultaneous door rise in ARMED
    IgnitionSignalOn = 1'b1;
    OpenDoorSign = 1'b1;
    tick();
    chk("ign_wins_state", AlarmState, 0);
    chk("ign_wins_led", ArmedLed, 0);
    IgnitionSignalOn = 1'b0;
    OpenDoorSign = 1'b0;

    // Re-arm, trigger, and reset in ALARM
    tick();
    chk("rearm_enter", AlarmState, 1);
    tickn(16);
    chk("rearm_armed", AlarmState, 2);
    OpenDoorSign = 1'b1;
    tick();
    OpenDoorSign = 1'b0;
    tickn(8);
    chk("pre_rst_alarm", AlarmState, 4);
    chk("pre_rst_siren", Siren, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_state",  AlarmState, 0);
    chk("async_rst_siren",  Siren, 0);
    chk("async_rst_buzzer", Buzzer, 0);
    chk("async_rst_led",    ArmedLed, 0);
`ifdef PASSIVE_ALARM_LOG_EN
    chk("async_rst_cnt", AlarmCount, 0);
`endif
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_arm", AlarmState, 1);
    tickn(16);
    chk("post_rst_armed", AlarmState, 2);

    // Repeated alarms; the log saturates at 15
    for (int n = 0; n < 17; n++) begin
      OpenDoorSign = 1'b1;
      tick();
      OpenDoorSign = 1'b0;
      tickn(8);
      chk($sformatf("rep_alarm%0d", n), AlarmState, 4);
`ifdef PASSIVE_ALARM_LOG_EN
      if (n == 0) chk("log_first", AlarmCount, 1);
`endif
      tickn(32);
      chk($sformatf("rep_armed%0d", n), AlarmState, 2);
    end
`ifdef PASSIVE_ALARM_LOG_EN
    chk("log_sat", AlarmCount, 15);
    IgnitionSignalOn = 1'b1;
    tick();
    chk("log_keep_on_disarm", AlarmCount, 15);
    IgnitionSignalOn = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/passive_alarm_ctrl.md
# passive_alarm_ctrl

Alarm sequencer directly downstream of the passive security block. It consumes the `PassiveSignal_s` (arm request) and `PassiveSignal_b` (warning-tone request) outputs, together with the `OpenDoorSign` and `IgnitionSignalOn` sensor lines that feed that block. From these it drives a siren, a buzzer and an armed indicator through a timed arm/entry/alarm state machine.

## Interface
Parameters:
- `ARM_DELAY_CYC`, default 16: cycles spent in ARM_DELAY before arming.
- `ENTRY_DELAY_CYC`, default 8: grace cycles after an intrusion before the siren sounds.
- `ALARM_CYC`, default 32: siren duration.
- `BEEP_HALF`, default 2: buzzer half-period in cycles.

Ports (clock and reset first):
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `PassiveSignal_s`  in  1  arm request level from the passive security block.
- `PassiveSignal_b`  in  1  warning-tone request level from the passive security block.
- `OpenDoorSign`  in  1  door open.
- `IgnitionSignalOn`  in  1  valid key/ignition; acts as disarm.
- `Siren`  out  1  registered siren drive.
- `Buzzer`  out  1  registered buzzer drive.
- `ArmedLed`  out  1  registered, high in ARMED, ENTRY_DELAY and ALARM.
- `AlarmState`  out  3  current state encoding.

## Operation
- All inputs are synchronous to `clk` and are sampled directly, with no synchronizer.
- `door_q` holds the previous `OpenDoorSign`. `door_rise = OpenDoorSign & ~door_q`.
- States and encodings: DISARMED=0, ARM_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4. Codes 5–7 go to DISARMED.
- Down-counter `dly`, width `$clog2` of the largest delay parameter, plus 1. It loads N-1 on entry to a timed state.
- DISARMED:
  - If `PassiveSignal_s & ~IgnitionSignalOn & ~OpenDoorSign`, go to ARM_DELAY and load `ARM_DELAY_CYC-1`.
- ARM_DELAY (checked in priority order):
  1. `IgnitionSignalOn` or `~PassiveSignal_s`: go to DISARMED.
  2. `OpenDoorSign`: reload `dly`, stay.
  3. `dly==0`: go to ARMED.
  4. Otherwise decrement.
- ARMED:
  1. `IgnitionSignalOn`: go to DISARMED.
  2. `door_rise`: go to ENTRY_DELAY and load `ENTRY_DELAY_CYC-1`.
- ENTRY_DELAY:
  1. `IgnitionSignalOn`: go to DISARMED.
  2. `dly==0`: go to ALARM and load `ALARM_CYC-1`.
  3. Otherwise decrement.
- ALARM:
  1. `IgnitionSignalOn`: go to DISARMED.
  2. `dly==0`: go to ARMED, with no re-trigger unless a new door rising edge occurs.
  3. Otherwise decrement.
- Beep generator:
  - Counter `bcnt` runs mod `BEEP_HALF`. Register `tone` toggles when `bcnt==BEEP_HALF-1`.
  - `bcnt` and `tone` clear on any state change.
- Output decode (registered from next state):
  - `Siren` = 1 only in ALARM.
  - `Buzzer` = `tone` in ENTRY_DELAY; `tone & PassiveSignal_b` in DISARMED; 0 otherwise.
  - `ArmedLed` = 1 in ARMED, ENTRY_DELAY and ALARM.

## Timing
- Reset, asynchronous: state DISARMED, `dly`=0, `door_q`=0, `bcnt`=0, `tone`=0, `Siren`=0, `Buzzer`=0, `ArmedLed`=0, `AlarmState`=0.
- An input sampled at edge k changes the state and all outputs at edge k (outputs are registered from next state). The effect is visible after edge k.
- Dwell time is exactly `ARM_DELAY_CYC`, `ENTRY_DELAY_CYC` or `ALARM_CYC` cycles, counted from the entry edge.
- Simultaneous events:
  - Ignition beats every other input.
  - A door rising edge on the same cycle that ARM_DELAY expires: door wins, counter reloads.
  - A door rising edge while in ENTRY_DELAY or ALARM is ignored.
- Reset asserted mid-operation forces DISARMED immediately. Release gives normal operation from the next edge.

## Configuration
- Macro `PASSIVE_ALARM_LOG_EN`.
- When defined:
  - Adds output `AlarmCount`, 4 bits.
  - Increments on each ENTRY_DELAY→ALARM transition and saturates at 15.
  - Clears only on `reset`; disarm does not clear it.
- When undefined: the port and the counter are absent, and behaviour is otherwise identical.

## Structure
- Package `passive_alarm_pkg` holds:
  - the state typedef and encodings;
  - default delay constants;
  - the `AlarmCount` width.
- One sub-module, `beep_gen`: `bcnt`/`tone` generator with a clear input, parameterized by `BEEP_HALF`.

## Test plan
- **Arm:** `PassiveSignal_s`=1, door/ignition 0 → ARM_DELAY next edge, ARMED after 16 cycles, `ArmedLed`=1.
- **Intrusion:** door rising edge in ARMED → ENTRY_DELAY, `Buzzer` toggles every 2 cycles, `Siren`=1 after 8 cycles, `Siren` returns to 0 after 32 cycles, back to ARMED.
- **Disarm in entry:** `IgnitionSignalOn`=1 on cycle 5 of ENTRY_DELAY → DISARMED next edge, `Siren` never 1.
- **Door during arming:** door high at cycle 10 of ARM_DELAY → counter reloads, ARMED 16 cycles after door closes.
- **Warning tone:** DISARMED with `PassiveSignal_b`=1 → `Buzzer` toggles at period 4; `PassiveSignal_b`=0 → `Buzzer`=0.
- **Reset / log:** reset asserted in ALARM → all outputs 0 asynchronously. With `PASSIVE_ALARM_LOG_EN`, 17 alarms → `AlarmCount`=15.
